// File: rtl/ras_stack_if.sv
// Fetch-side handshake bundle for the return address stack: call/return
// classification, checkpoint control, and the predicted return target.
interface ras_stack_if;
    logic        push;
    logic        pop;
    logic [31:0] new_addr;
    logic        branch_fetched;
    logic        branch_retired;
    logic        flush;
    logic [31:0] addr;
    logic        valid;
    logic        track_full;

    modport master (
        output push, pop, new_addr, branch_fetched, branch_retired, flush,
        input  addr, valid, track_full
    );

    modport slave (
        input  push, pop, new_addr, branch_fetched, branch_retired, flush,
        output addr, valid, track_full
    );
endinterface

// File: rtl/ras_stack.sv
// Speculative return address stack with a FIFO of pointer checkpoints,
// one per in-flight control-flow instruction, used to roll back on flush.
module ras_stack #(
    parameter int STACK_DEPTH = 4,
    parameter int TRACK_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    ras_stack_if.slave bus
);
    localparam int SI_W = $clog2(STACK_DEPTH);
    localparam int SC_W = SI_W + 1;
    localparam int TI_W = $clog2(TRACK_DEPTH);
    localparam int TO_W = TI_W + 1;
    localparam logic [SC_W-1:0] CNT_MAX = SC_W'(STACK_DEPTH);
    localparam logic [TO_W-1:0] OCC_MAX = TO_W'(TRACK_DEPTH);

    logic [31:0]     r_stack  [STACK_DEPTH];
    logic [SI_W-1:0] r_ck_idx [TRACK_DEPTH];
    logic [SC_W-1:0] r_ck_cnt [TRACK_DEPTH];

    logic [SI_W-1:0] r_rd_idx;
    logic [SC_W-1:0] r_count;
    logic [TI_W-1:0] r_head;
    logic [TI_W-1:0] r_tail;
    logic [TO_W-1:0] r_occ;

    logic            w_empty;
    logic            w_full;
    logic            w_enq;
    logic            w_deq;
    logic            w_valid;
    logic            w_wr_en;
    logic [SI_W-1:0] w_wr_idx;
    logic [SI_W-1:0] w_idx_nxt;
    logic [SC_W-1:0] w_cnt_nxt;

    assign w_empty = (r_occ == '0);
    assign w_full  = (r_occ == OCC_MAX);
    // A retire in the same cycle frees the head slot, so a full FIFO still accepts.
    assign w_enq   = bus.branch_fetched && (!w_full || bus.branch_retired);
    assign w_deq   = bus.branch_retired && !w_empty;
    assign w_valid = (r_count != '0);

    assign bus.valid      = w_valid;
    assign bus.addr       = w_valid ? r_stack[r_rd_idx] : 32'd0;
    assign bus.track_full = w_full;

    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_idx  = r_rd_idx;
        w_idx_nxt = r_rd_idx;
        w_cnt_nxt = r_count;
        if (bus.push && !bus.pop) begin
            w_wr_en   = 1'b1;
            w_wr_idx  = r_rd_idx + SI_W'(1);
            w_idx_nxt = r_rd_idx + SI_W'(1);
            if (r_count != CNT_MAX) w_cnt_nxt = r_count + SC_W'(1);
        end else if (bus.pop && !bus.push) begin
            w_idx_nxt = r_rd_idx - SI_W'(1);
            if (r_count != '0) w_cnt_nxt = r_count - SC_W'(1);
        end else if (bus.push && bus.pop) begin
            // Return immediately followed by a call: replace the top in place.
            w_wr_en = 1'b1;
            if (r_count == '0) w_cnt_nxt = SC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_idx <= '0;
            r_count  <= '0;
            r_head   <= '0;
            r_tail   <= '0;
            r_occ    <= '0;
        end else if (bus.flush) begin
            if (!w_empty) begin
                r_rd_idx <= r_ck_idx[r_head];
                r_count  <= r_ck_cnt[r_head];
            end
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            r_rd_idx <= w_idx_nxt;
            r_count  <= w_cnt_nxt;
            if (w_enq) r_tail <= r_tail + TI_W'(1);
            if (w_deq) r_head <= r_head + TI_W'(1);
            if (w_enq && !w_deq)      r_occ <= r_occ + TO_W'(1);
            else if (w_deq && !w_enq) r_occ <= r_occ - TO_W'(1);
        end
    end

    // Storage arrays carry no reset; a zero count hides stale entries.
    always_ff @(posedge clk) begin
        if (!rst && !bus.flush) begin
            if (w_wr_en) r_stack[w_wr_idx] <= bus.new_addr;
            if (w_enq) begin
                r_ck_idx[r_tail] <= r_rd_idx;
                r_ck_cnt[r_tail] <= r_count;
            end
            assert (!(bus.branch_fetched && w_full && !bus.branch_retired));
        end
    end
endmodule

// File: tb/tb_ras_stack.sv
// Directed bench for ras_stack: an abstract model (unbounded top position,
// queue of checkpoints) is compared every cycle, plus hand-computed literals.
module tb_ras_stack;
    localparam int SD = 4;
    localparam int TD = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    ras_stack_if bus ();

    ras_stack #(.STACK_DEPTH(SD), .TRACK_DEPTH(TD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    typedef struct { int top; int cnt; } ck_t;
    logic [31:0] m_mem [SD];
    int          m_top;
    int          m_cnt;
    ck_t         m_ck [$];

    function automatic int slot(input int t);
        return ((t % SD) + SD) % SD;
    endfunction

    function automatic logic [31:0] m_addr();
        return (m_cnt > 0) ? m_mem[slot(m_top)] : 32'd0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        ck_t pre;
        bit  full;
        if (rst) begin
            m_top = 0;
            m_cnt = 0;
            m_ck.delete();
        end else if (bus.flush) begin
            if (m_ck.size() > 0) begin
                m_top = m_ck[0].top;
                m_cnt = m_ck[0].cnt;
            end
            m_ck.delete();
        end else begin
            pre.top = m_top;
            pre.cnt = m_cnt;
            full = (m_ck.size() == TD);
            if (bus.branch_retired && m_ck.size() > 0) void'(m_ck.pop_front());
            if (bus.branch_fetched && (!full || bus.branch_retired)) m_ck.push_back(pre);
            if (bus.push && !bus.pop) begin
                m_top++;
                m_mem[slot(m_top)] = bus.new_addr;
                if (m_cnt < SD) m_cnt++;
            end else if (bus.pop && !bus.push) begin
                m_top--;
                if (m_cnt > 0) m_cnt--;
            end else if (bus.push && bus.pop) begin
                m_mem[slot(m_top)] = bus.new_addr;
                if (m_cnt == 0) m_cnt = 1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_addr", bus.addr, m_addr());
            chk("cyc_valid", {31'd0, bus.valid}, (m_cnt > 0) ? 32'd1 : 32'd0);
            chk("cyc_track_full", {31'd0, bus.track_full}, (m_ck.size() == TD) ? 32'd1 : 32'd0);
        end
    end

    task automatic step(input logic r, input logic p, input logic q, input logic [31:0] a,
                        input logic bf, input logic br, input logic fl);
        rst                = r;
        bus.push           = p;
        bus.pop            = q;
        bus.new_addr       = a;
        bus.branch_fetched = bf;
        bus.branch_retired = br;
        bus.flush          = fl;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        cmp_en = 1'b1;
        chk("reset_valid", {31'd0, bus.valid}, 32'd0);
        chk("reset_addr", bus.addr, 32'd0);
        chk("reset_track_full", {31'd0, bus.track_full}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_out(input string name, input logic [31:0] ea, input logic ev);
        chk({name, "_addr"}, bus.addr, ea);
        chk({name, "_valid"}, {31'd0, bus.valid}, {31'd0, ev});
    endtask

    initial begin
        bus.push = 1'b0; bus.pop = 1'b0; bus.new_addr = '0;
        bus.branch_fetched = 1'b0; bus.branch_retired = 1'b0; bus.flush = 1'b0;

        // Basic push/pop ordering
        do_reset();
        step(0, 1, 0, 32'h100, 1, 0, 0);
        step(0, 1, 0, 32'h200, 1, 0, 0);
        step(0, 1, 0, 32'h300, 1, 0, 0);
        expect_out("push3", 32'h300, 1'b1);
        chk("model_cnt3", m_cnt, 32'd3);
        step(0, 0, 1, 32'h0, 1, 0, 0);
        expect_out("pop1", 32'h200, 1'b1);
        step(0, 0, 1, 32'h0, 1, 0, 0);
        expect_out("pop2", 32'h100, 1'b1);
        step(0, 0, 1, 32'h0, 1, 0, 0);
        expect_out("pop3", 32'h0, 1'b0);

        // Overflow wraps onto the oldest slot; flush exposes the overwritten slot
        do_reset();
        step(0, 1, 0, 32'h10, 1, 0, 0);
        step(0, 1, 0, 32'h20, 1, 1, 0);
        step(0, 1, 0, 32'h30, 1, 1, 0);
        step(0, 1, 0, 32'h40, 1, 1, 0);
        step(0, 1, 0, 32'h50, 1, 1, 0);
        expect_out("ovf_push5", 32'h50, 1'b1);
        chk("model_cnt_sat", m_cnt, 32'd4);
        step(0, 0, 1, 32'h0, 1, 1, 0);
        expect_out("ovf_pop1", 32'h40, 1'b1);
        step(0, 0, 1, 32'h0, 1, 0, 0);
        expect_out("ovf_pop2", 32'h30, 1'b1);
        step(0, 0, 1, 32'h0, 1, 0, 0);
        expect_out("ovf_pop3", 32'h20, 1'b1);
        step(0, 0, 1, 32'h0, 1, 0, 0);
        expect_out("ovf_pop4", 32'h0, 1'b0);
        step(0, 0, 0, 32'h0, 0, 0, 1);
        expect_out("ovf_wrapped_slot", 32'h50, 1'b1);

        // Simultaneous push+pop replaces the top
        do_reset();
        step(0, 1, 0, 32'hA0, 1, 0, 0);
        step(0, 1, 1, 32'hB0, 1, 0, 0);
        expect_out("pp_replace", 32'hB0, 1'b1);
        chk("model_cnt_pp", m_cnt, 32'd1);
        step(0, 0, 1, 32'h0, 1, 0, 0);
        expect_out("pp_pop", 32'h0, 1'b0);
        step(0, 1, 1, 32'hC0, 1, 0, 0);
        expect_out("pp_empty", 32'hC0, 1'b1);

        // Flush rolls back to the oldest unretired checkpoint
        do_reset();
        step(0, 1, 0, 32'h100, 1, 0, 0);
        step(0, 1, 0, 32'h200, 1, 1, 0);
        step(0, 1, 0, 32'h300, 1, 0, 0);
        expect_out("fl_pre", 32'h300, 1'b1);
        step(0, 0, 0, 32'h0, 0, 0, 1);
        expect_out("fl_restore", 32'h100, 1'b1);
        chk("fl_track_full", {31'd0, bus.track_full}, 32'd0);
        chk("model_ck_empty", m_ck.size(), 32'd0);
        step(0, 0, 0, 32'h0, 0, 1, 0);
        expect_out("fl_retire_empty", 32'h100, 1'b1);

        // Checkpoint FIFO fill, full-with-retire, drain by one
        do_reset();
        for (int i = 0; i < TD; i++) begin
            step(0, 1, 0, 32'h1000 + 32'(i), 1, 0, 0);
            if (i == TD - 2) chk("trk_not_full", {31'd0, bus.track_full}, 32'd0);
        end
        chk("trk_full", {31'd0, bus.track_full}, 32'd1);
        expect_out("trk_top", 32'h1007, 1'b1);
        step(0, 1, 0, 32'h1008, 1, 1, 0);
        chk("trk_full_swap", {31'd0, bus.track_full}, 32'd1);
        expect_out("trk_swap_top", 32'h1008, 1'b1);
        step(0, 0, 0, 32'h0, 0, 1, 0);
        chk("trk_drain", {31'd0, bus.track_full}, 32'd0);

        // Flush outranks push and retire
        do_reset();
        step(0, 1, 0, 32'h55, 1, 0, 0);
        step(0, 0, 0, 32'h0, 0, 1, 0);
        step(0, 1, 0, 32'h999, 0, 1, 1);
        expect_out("flp_ignore_push", 32'h55, 1'b1);
        step(0, 0, 0, 32'h0, 0, 1, 0);
        expect_out("flp_retire_empty", 32'h55, 1'b1);
        step(0, 1, 0, 32'h77, 1, 0, 0);
        expect_out("flp_push77", 32'h77, 1'b1);
        step(0, 0, 0, 32'h0, 0, 0, 1);
        expect_out("flp_rollback", 32'h55, 1'b1);

        // Reset mid-operation
        step(0, 1, 0, 32'h88, 1, 0, 0);
        do_reset();
        expect_out("midrst", 32'h0, 1'b0);

        step(0, 0, 0, 32'h0, 0, 0, 0);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
